maze_store: RTL and testbench
=============================

MAZE_STORE -- requirements
Module: maze_store

Interface
REQ-001 SHALL provide parameter maze_width, default 6, coordinate width; maze is 2^maze_width x 2^maze_width cells (64x64 at default).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port load_valid  input  1  loader has a wall byte on load_data.
REQ-005 SHALL have port load_data  input  8  eight wall bits, 1 = wall, 0 = free.
REQ-006 SHALL have port load_ready  output  1  block accepts a load beat this cycle.
REQ-007 SHALL have port loaded  output  1  maze image complete; solver may run.
REQ-008 SHALL have ports row, col  input  maze_width each  solver cell select.
REQ-009 SHALL have port maze_oe  input  1  synchronous read request at [row, col].
REQ-010 SHALL have port maze_we  input  1  synchronous mark-visited request at [row, col].
REQ-011 SHALL have port done  input  1  solver has found the exit.
REQ-012 SHALL have port maze_in  output  1  registered wall bit of last read cell.
REQ-013 SHALL have port visit_count  output  2*maze_width+1  number of distinct cells marked visited.
REQ-014 SHALL have port finished  output  1  done captured; block frozen.

Function
REQ-015 SHALL hold two bitmaps of 2^(2*maze_width) bits: wall map and visited map, indexed {row, col} row-major.
REQ-016 SHALL implement states LOAD, SERVE, HOLD; reset enters LOAD.
REQ-017 In LOAD: load_ready = 1; a beat is accepted when load_valid && load_ready.
REQ-018 Each accepted beat SHALL write load_data[k] to wall cell at linear address addr+k (k = 0..7, bit 0 = lowest column) and clear the same 8 visited bits; addr then advances by 8.
REQ-019 addr SHALL start at 0; beats without load_valid SHALL leave addr and maps unchanged.
REQ-020 On acceptance of the final beat (addr = 2^(2*maze_width) - 8; beat 512 at default) SHALL go to SERVE; loaded = 1 and load_ready = 0 from the next cycle.
REQ-021 Outside LOAD: load_ready = 0; load_valid/load_data ignored.
REQ-022 In LOAD: maze_oe, maze_we, done ignored; maze_in = 1 (wall, safe default).
REQ-023 In SERVE: maze_oe high at cycle N SHALL give maze_in = wall[row][col] at cycle N+1 (1-cycle latency); maze_oe low SHALL hold maze_in.
REQ-024 In SERVE: maze_we high SHALL set visited[row][col] = 1; visit_count increments by 1 only if the bit was 0; re-marking a cell leaves count unchanged.
REQ-025 maze_oe and maze_we in the same cycle SHALL both execute; read returns wall bit, unaffected by the visited write.
REQ-026 visit_count width (2*maze_width+1) SHALL hold 2^(2*maze_width) without overflow; no wrap.
REQ-027 done high in SERVE SHALL move to HOLD next cycle; an oe/we in that same cycle still executes.
REQ-028 In HOLD: finished = 1; oe/we ignored; maze_in, visit_count, maps frozen; exit only by rst.
REQ-029 done high in LOAD SHALL be ignored.

Reset
REQ-030 rst high at a rising edge SHALL force: state LOAD, addr 0, load_ready 1, loaded 0, maze_in 1, visit_count 0, finished 0.
REQ-031 Wall map need not be cleared by reset; it is fully rewritten by the next load; visited bits are cleared by REQ-018.
REQ-032 rst mid-load SHALL restart at addr 0, discarding progress; rst in SERVE/HOLD SHALL return to LOAD.

Verification
REQ-033 Stream 512 beats with load_valid toggling 1/0 -> addr advances only on valid beats; loaded rises the cycle after beat 512; load_ready falls same cycle.
REQ-034 Load byte 0 = 8'h05, then maze_oe at (0,0),(0,1),(0,2) on consecutive cycles -> maze_in 1,0,1 one cycle after each.
REQ-035 maze_we at (3,4) twice, then (3,5) -> visit_count 1,1,2; simultaneous oe+we at (3,6) wall cell -> maze_in 1, count 3.
REQ-036 done pulse with maze_we at (7,7) -> count increments once, finished = 1 next cycle; later oe/we produce no change.
REQ-037 rst after 100 load beats, then full 512-beat reload -> loaded after beat 512 of reload, visit_count 0, map equals reload data.
REQ-038 Mark all 4096 cells -> visit_count = 4096 (13'h1000), no wrap.

Source files
------------

// File: rtl/maze_store.sv
// maze_store -- wall and visited bitmaps for a 2^maze_width x 2^maze_width maze.
//
// The maze image is streamed in one byte (eight cells) per accepted beat.
// After the last beat the block serves single-cell wall reads and
// mark-visited writes for a solver. A done pulse freezes the block until
// the next reset.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   load_valid   loader presents a wall byte on load_data
//   load_data    eight wall bits (1 = wall); bit 0 is the lowest column
//   load_ready   block accepts a load beat this cycle
//   loaded       maze image complete, solver may run
//   row, col     solver cell select
//   maze_oe      read request, wall bit appears on maze_in next cycle
//   maze_we      mark-visited request
//   done         solver has found the exit
//   maze_in      registered wall bit of the last read cell
//   visit_count  number of distinct cells marked visited
//   finished     done has been captured, block frozen
//
// state | meaning
// ------+----------------------------------------------------------------
// LOAD  | accepting wall bytes; solver inputs ignored; maze_in held at 1
// SERVE | solver reads walls and marks cells visited
// HOLD  | done captured; everything frozen until reset

module maze_store #(
   parameter int maze_width = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   input  logic [7:0]              load_data,
   output logic                    load_ready,
   output logic                    loaded,
   input  logic [maze_width-1:0]   row,
   input  logic [maze_width-1:0]   col,
   input  logic                    maze_oe,
   input  logic                    maze_we,
   input  logic                    done,
   output logic                    maze_in,
   output logic [2*maze_width:0]   visit_count,
   output logic                    finished
);

   localparam int cell_bits = 2 * maze_width;
   localparam int byte_aw   = cell_bits - 3;
   localparam int num_bytes = 2 ** byte_aw;

   localparam logic [byte_aw-1:0]  addr_one  = 1;
   localparam logic [byte_aw-1:0]  addr_last = '1;
   localparam logic [cell_bits:0]  count_one = 1;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SERVE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [byte_aw-1:0]   addr_q, addr_d;
   logic                 maze_in_q, maze_in_d;
   logic [cell_bits:0]   count_q, count_d;

   // Maps are stored byte-wide so a load beat is a single word write.
   logic [7:0]           wall_q    [num_bytes];
   logic [7:0]           visited_q [num_bytes];

   logic                 wall_wr_en;
   logic                 vis_clr_en;
   logic                 vis_set_en;

   logic [cell_bits-1:0] rd_lin;
   logic [byte_aw-1:0]   rd_byte;
   logic [2:0]           rd_bit;
   logic                 rd_wall;
   logic                 rd_visited;

   assign rd_lin     = {row, col};
   assign rd_byte    = rd_lin[cell_bits-1:3];
   assign rd_bit     = rd_lin[2:0];
   assign rd_wall    = wall_q[rd_byte][rd_bit];
   assign rd_visited = visited_q[rd_byte][rd_bit];

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      maze_in_d  = maze_in_q;
      count_d    = count_q;
      wall_wr_en = 1'b0;
      vis_clr_en = 1'b0;
      vis_set_en = 1'b0;

      case (state_q)
         ST_LOAD: begin
            maze_in_d = 1'b1;
            if (load_valid) begin
               wall_wr_en = 1'b1;
               vis_clr_en = 1'b1;
               addr_d     = addr_q + addr_one;
               if (addr_q == addr_last) begin
                  state_d = ST_SERVE;
               end
            end
         end
         ST_SERVE: begin
            // Read sees the wall map only, so a same-cycle visited write
            // cannot disturb it.
            if (maze_oe) begin
               maze_in_d = rd_wall;
            end
            if (maze_we) begin
               vis_set_en = 1'b1;
               if (!rd_visited) begin
                  count_d = count_q + count_one;
               end
            end
            if (done) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase

      // A reset cycle must not leave partial writes behind in the maps.
      if (rst) begin
         wall_wr_en = 1'b0;
         vis_clr_en = 1'b0;
         vis_set_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_LOAD;
         addr_q    <= '0;
         maze_in_q <= 1'b1;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         maze_in_q <= maze_in_d;
         count_q   <= count_d;
      end
   end

   // Maps carry no reset: every load rewrites all wall bytes and clears
   // every visited byte before SERVE can be reached.
   always_ff @(posedge clk) begin
      if (wall_wr_en) begin
         wall_q[addr_q] <= load_data;
      end
      if (vis_clr_en) begin
         visited_q[addr_q] <= '0;
      end else if (vis_set_en) begin
         visited_q[rd_byte][rd_bit] <= 1'b1;
      end
   end

   assign load_ready  = (state_q == ST_LOAD);
   assign loaded      = (state_q != ST_LOAD);
   assign finished    = (state_q == ST_HOLD);
   assign maze_in     = maze_in_q;
   assign visit_count = count_q;

endmodule

// File: tb/tb_maze_store.sv
module tb_maze_store;

   localparam int MW     = 6;
   localparam int NCELL  = 4096;
   localparam int NBYTE  = 512;
   localparam int CELL77 = 7 * 64 + 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_valid;
   logic [7:0]    load_data;
   logic          load_ready;
   logic          loaded;
   logic [MW-1:0] row;
   logic [MW-1:0] col;
   logic          maze_oe;
   logic          maze_we;
   logic          done;
   logic          maze_in;
   logic [12:0]   visit_count;
   logic          finished;

   maze_store #(.maze_width(MW)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .loaded      (loaded),
      .row         (row),
      .col         (col),
      .maze_oe     (maze_oe),
      .maze_we     (maze_we),
      .done        (done),
      .maze_in     (maze_in),
      .visit_count (visit_count),
      .finished    (finished)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: plain arrays and flags following the block's rules.
   bit   m_wall [NCELL];
   bit   m_vis  [NCELL];
   bit   m_loaded;
   bit   m_finished;
   bit   m_in;
   int   m_beats;
   int   m_count;

   logic [7:0] ld1 [NBYTE];
   logic [7:0] ld2 [NBYTE];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      int idx;
      @(posedge clk);
      idx = int'({row, col});
      if (rst) begin
         m_loaded   = 0;
         m_finished = 0;
         m_beats    = 0;
         m_in       = 1;
         m_count    = 0;
      end else if (!m_loaded) begin
         if (load_valid) begin
            for (int k = 0; k < 8; k++) begin
               m_wall[m_beats*8 + k] = load_data[k];
               m_vis[m_beats*8 + k]  = 0;
            end
            m_beats++;
            if (m_beats == NBYTE) m_loaded = 1;
         end
      end else if (!m_finished) begin
         if (maze_oe) m_in = m_wall[idx];
         if (maze_we) begin
            if (!m_vis[idx]) m_count++;
            m_vis[idx] = 1;
         end
         if (done) m_finished = 1;
      end
      #1;
      chk("load_ready",  32'(load_ready),  32'(!m_loaded));
      chk("loaded",      32'(loaded),      32'(m_loaded));
      chk("finished",    32'(finished),    32'(m_finished));
      chk("maze_in",     32'(maze_in),     32'(m_in));
      chk("visit_count", 32'(visit_count), 32'(m_count));
   endtask

   task automatic idle();
      rst        = 0;
      load_valid = 0;
      load_data  = 8'h00;
      row        = '0;
      col        = '0;
      maze_oe    = 0;
      maze_we    = 0;
      done       = 0;
   endtask

   task automatic rand_solver(input bit allow_done);
      row     = MW'($urandom);
      col     = MW'($urandom);
      maze_oe = 1'($urandom);
      maze_we = 1'($urandom);
      done    = allow_done ? ($urandom_range(0, 3) == 0) : 1'b0;
   endtask

   task automatic set_cell(input int idx);
      row = MW'(idx / 64);
      col = MW'(idx % 64);
   endtask

   initial begin
      int sent;
      int cyc;
      int idx;
      logic [7:0] b;

      for (int i = 0; i < NBYTE; i++) begin
         ld1[i] = 8'($urandom);
         ld2[i] = 8'($urandom);
      end
      ld1[0]  = 8'h05;
      ld1[24] = ld1[24] | 8'h40;   // cell (3,6) is a wall

      idle();
      rst = 1;
      tick();
      tick();
      chk("rst_ready",  32'(load_ready),  32'd1);
      chk("rst_maze_in", 32'(maze_in),    32'd1);
      chk("rst_count",  32'(visit_count), 32'd0);
      rst = 0;

      // Full load with load_valid alternating; solver inputs must be ignored.
      sent = 0;
      cyc  = 0;
      while (sent < NBYTE && cyc < 4000) begin
         load_valid = (cyc % 2 == 0);
         load_data  = load_valid ? ld1[sent] : 8'($urandom);
         rand_solver(1);
         tick();
         if (load_valid) sent++;
         if (sent == NBYTE) begin
            chk("loaded_rise", 32'(loaded),     32'd1);
            chk("ready_fall",  32'(load_ready), 32'd0);
         end else begin
            chk("loaded_early", 32'(loaded), 32'd0);
         end
         cyc++;
      end
      chk("load1_beats", 32'(sent), 32'(NBYTE));
      idle();

      // Reads of byte 0 = 8'h05.
      maze_oe = 1;
      for (int c = 0; c < 3; c++) begin
         col = MW'(c);
         tick();
         chk("rd_byte0", 32'(maze_in), (c == 1) ? 32'd0 : 32'd1);
      end
      maze_oe = 0;
      tick();

      // Visit counting and simultaneous read/write.
      maze_we = 1;
      row = 3; col = 4; tick(); chk("cnt_34a", 32'(visit_count), 32'd1);
      tick();                   chk("cnt_34b", 32'(visit_count), 32'd1);
      col = 5;          tick(); chk("cnt_35",  32'(visit_count), 32'd2);
      maze_oe = 1;
      col = 6;          tick();
      chk("rdwr_36_in",  32'(maze_in),     32'd1);
      chk("rdwr_36_cnt", 32'(visit_count), 32'd3);
      idle();

      // Random serving, never touching (7,7) with a write.
      for (int i = 0; i < 3000; i++) begin
         rand_solver(0);
         load_valid = 1'($urandom);
         load_data  = 8'($urandom);
         if (int'({row, col}) == CELL77) maze_we = 0;
         tick();
      end
      idle();

      // Mark every cell except (7,7).
      maze_we = 1;
      for (int i = 0; i < NCELL; i++) begin
         if (i != CELL77) begin
            set_cell(i);
            tick();
         end
      end
      chk("cnt_4095", 32'(visit_count), 32'd4095);

      // done together with the last new cell.
      set_cell(CELL77);
      done = 1;
      tick();
      chk("cnt_4096", 32'(visit_count), 32'h1000);
      chk("fin_set",  32'(finished),    32'd1);
      idle();
      for (int i = 0; i < 20; i++) begin
         rand_solver(1);
         load_valid = 1'($urandom);
         tick();
         chk("hold_cnt", 32'(visit_count), 32'h1000);
      end
      idle();

      // Reset from HOLD, abandon a partial load, then reload.
      rst = 1;
      tick();
      rst = 0;
      load_valid = 1;
      for (int i = 0; i < 100; i++) begin
         load_data = 8'($urandom);
         tick();
      end
      rst = 1;
      tick();
      chk("rst_mid_loaded", 32'(loaded), 32'd0);
      rst = 0;

      sent = 0;
      cyc  = 0;
      while (sent < NBYTE && cyc < 4000) begin
         load_valid = ($urandom_range(0, 9) < 7);
         load_data  = load_valid ? ld2[sent] : 8'($urandom);
         rand_solver(1);
         tick();
         if (load_valid) sent++;
         cyc++;
      end
      chk("load2_beats",  32'(sent),        32'(NBYTE));
      chk("load2_loaded", 32'(loaded),      32'd1);
      chk("load2_count",  32'(visit_count), 32'd0);
      idle();

      // Full map readback against reload data.
      maze_oe = 1;
      for (int i = 0; i < NCELL; i++) begin
         set_cell(i);
         tick();
         b = ld2[i / 8];
         chk("map2", 32'(maze_in), 32'(b[i % 8]));
      end
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
